// File: rtl/simplez_core.sv
// simplez_core: multi-cycle accumulator CPU for the Simplez ISA.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   mem_req/mem_we   : memory request / write strobe (qualified by mem_req)
//   mem_addr         : transaction address
//   mem_wdata        : write data, always the accumulator
//   mem_rdata/mem_ack: read data and completion handshake
//   step_en/step     : single-step mode enable / release pulse
//   pc, acc, zflag   : architectural state
//   halted           : HALT instruction has executed
//
// Instruction format: CO = ri[DW-1:DW-3], COE = ri[DW-1:DW-4], CD = ri[AW-1:0].
// Bus outputs are registered; a new request is raised on the same edge that
// leaves the previous state, so a zero-wait-state access costs one cycle.
module simplez_core #(
  parameter int AW          = 9,
  parameter int DW          = 12,
  parameter int WAIT_CYCLES = 2400000
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  input  logic          step_en,
  input  logic          step,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc,
  output logic          zflag,
  output logic          halted
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [2:0] OP_ST  = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_BR  = 3'd3;
  localparam logic [2:0] OP_BZ  = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;
  localparam logic [2:0] OP_DEC = 3'd6;
  localparam logic [2:0] OP_EXT = 3'd7;
  localparam logic [3:0] COE_HALT = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WAIT, S_HALT
  } state_t;

  state_t        state;
  logic [DW-1:0] ri;
  logic [CW-1:0] wcnt;

  logic [2:0]    co;
  logic [3:0]    coe;
  logic [AW-1:0] cd;
  logic [AW-1:0] pc_inc;
  logic [DW-1:0] sum;
  logic          go_bound;
  logic [AW-1:0] nxt_pc;

  assign co        = ri[DW-1:DW-3];
  assign coe       = ri[DW-1:DW-4];
  assign cd        = ri[AW-1:0];
  assign pc_inc    = pc + AW'(1);
  assign sum       = acc + mem_rdata;
  assign mem_wdata = acc;

  // Instruction boundary: every path that retires an instruction sets
  // go_bound and the pc it leaves behind.
  always_comb begin
    go_bound = 1'b0;
    nxt_pc   = pc;
    case (state)
      S_EXEC: begin
        case (co)
          OP_BR:          begin go_bound = 1'b1; nxt_pc = cd; end
          OP_BZ:          begin go_bound = 1'b1; nxt_pc = zflag ? cd : pc_inc; end
          OP_CLR, OP_DEC: begin go_bound = 1'b1; nxt_pc = pc_inc; end
          default: ;
        endcase
      end
      S_MEM:  if (mem_ack)    begin go_bound = 1'b1; nxt_pc = pc_inc; end
      S_WAIT: if (wcnt == '0) begin go_bound = 1'b1; nxt_pc = pc_inc; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= '0;
      acc      <= '0;
      zflag    <= 1'b0;
      ri       <= '0;
      halted   <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      wcnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!step_en || step) begin
            state    <= S_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        S_FETCH: begin
          // Only the first cycle out of reset arrives here without a request.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ri      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (co)
            OP_ST, OP_LD, OP_ADD: begin
              state    <= S_MEM;
              mem_req  <= 1'b1;
              mem_we   <= (co == OP_ST);
              mem_addr <= cd;
            end
            OP_CLR: begin
              acc   <= '0;
              zflag <= 1'b1;
            end
            OP_DEC: begin
              acc   <= acc - DW'(1);
              zflag <= (acc == DW'(1));
            end
            OP_EXT: begin
              if (coe == COE_HALT) begin
                state  <= S_HALT;
                halted <= 1'b1;
              end else begin
                wcnt  <= CW'(WAIT_CYCLES - 1);
                state <= S_WAIT;
              end
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (co == OP_LD) begin
              acc   <= mem_rdata;
              zflag <= (mem_rdata == '0);
            end else if (co == OP_ADD) begin
              acc   <= sum;
              zflag <= (sum == '0);
            end
          end
        end
        S_WAIT:  if (wcnt != '0) wcnt <= wcnt - CW'(1);
        S_HALT:  ;
        default: state <= S_FETCH;
      endcase

      if (go_bound) begin
        pc <= nxt_pc;
        if (step_en) begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end else begin
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= nxt_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_simplez_core.sv
// Self-checking bench for simplez_core (AW=9, DW=12, WAIT_CYCLES=5).
// A bus responder with programmable latency serves the core from ram[];
// an instruction-level interpreter over ref_mem[] predicts architectural
// state, transaction counts and cycle counts.
module tb_simplez_core;
  localparam int AW = 9, DW = 12, WC = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          step_en = 1'b0;
  logic          step = 1'b0;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
  logic          zflag, halted;

  simplez_core #(.AW(AW), .DW(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .step_en(step_en), .step(step), .pc(pc), .acc(acc),
    .zflag(zflag), .halted(halted)
  );

  always #5 clk = ~clk;

  int vec = 0, bad = 0;

  logic [DW-1:0] ram[512];
  logic [DW-1:0] ref_mem[512];

  // responder controls
  int lat = 0;
  bit spur = 0;
  bit hold_wr = 0;
  int n_xact = 0;
  int wcnt = 0;
  bit pend = 0;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [DW-1:0] s_wd;

  // Responder + bus-protocol monitor. Decisions made here take effect at
  // the following rising edge; stimulus changes at negedge+1.
  always @(negedge clk) begin
    if (rst) begin
      pend = 0; wcnt = 0; mem_ack = 1'b0;
    end else if (mem_req) begin
      if (pend) begin
        vec++;
        if (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wd) begin
          bad++;
          $display("FAIL bus_hold addr=%h want %h we=%b want %b wdata=%h want %h",
                   mem_addr, s_addr, mem_we, s_we, mem_wdata, s_wd);
        end
      end
      if (!(hold_wr && mem_we) && wcnt >= lat) begin
        mem_ack = 1'b1;
        mem_rdata = ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
        n_xact++;
        wcnt = 0; pend = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++; pend = 1;
        s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata;
      end
    end else begin
      if (pend) begin
        vec++; bad++;
        $display("FAIL req_drop mem_req=0 want 1 (no ack given)");
      end
      pend = 0; wcnt = 0;
      mem_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = DW'($urandom);
    end
  end

  // ---------------- reference interpreter ----------------
  int m_pc, m_acc;
  bit m_z;

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_z = 0;
  endtask

  // Executes one instruction; returns cycles (with L extra per transaction),
  // number of bus transactions, and whether it halted.
  task automatic model_step(input int L, output int cyc, output int nx, output bit h);
    int ins, op, cd;
    ins = int'(ref_mem[m_pc]);
    op  = ins / 512;
    cd  = ins % 512;
    h = 0; nx = 1; cyc = 2;
    case (op)
      0: begin ref_mem[cd] = DW'(m_acc); m_pc = (m_pc + 1) % 512; nx = 2; cyc = 3; end
      1: begin m_acc = int'(ref_mem[cd]); m_z = (m_acc == 0); m_pc = (m_pc + 1) % 512; nx = 2; cyc = 3; end
      2: begin m_acc = (m_acc + int'(ref_mem[cd])) % 4096; m_z = (m_acc == 0); m_pc = (m_pc + 1) % 512; nx = 2; cyc = 3; end
      3: m_pc = cd;
      4: m_pc = m_z ? cd : (m_pc + 1) % 512;
      5: begin m_acc = 0; m_z = 1; m_pc = (m_pc + 1) % 512; end
      6: begin m_acc = (m_acc + 4095) % 4096; m_z = (m_acc == 0); m_pc = (m_pc + 1) % 512; end
      default: begin
        if (ins / 256 == 14) h = 1;
        else begin cyc = WC + 2; m_pc = (m_pc + 1) % 512; end
      end
    endcase
    cyc = cyc + L * nx;
  endtask

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) begin ram[i] = '0; ref_mem[i] = '0; end
  endtask

  task automatic poke(input int a, input int v);
    ram[a] = DW'(v); ref_mem[a] = DW'(v);
  endtask

  // Leaves the bench one cycle after the first non-reset edge.
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic run_to_halt(output int t);
    t = 0;
    while (!halted && t < 500) begin tick(1); t++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_mem();
    poke(0, 'h600);               // BR 0
    lat = 0; step_en = 0;
    rst = 1'b1;
    tick(2);
    vec++; if (pc !== 9'd0)    begin bad++; $display("FAIL rst_pc got %h want 0", pc); end
    vec++; if (acc !== 12'd0)  begin bad++; $display("FAIL rst_acc got %h want 0", acc); end
    vec++; if (zflag !== 1'b0) begin bad++; $display("FAIL rst_z got %b want 0", zflag); end
    vec++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got %b want 0", halted); end
    vec++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_bus req=%b we=%b want 0 0", mem_req, mem_we); end
    rst = 1'b0;
    tick(1);
    vec++; if (mem_req !== 1'b1 || mem_addr !== 9'd0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL rst_first_fetch req=%b addr=%h we=%b want 1 0 0", mem_req, mem_addr, mem_we);
    end
  endtask

  task automatic test_ld_add_st(input int L, input int want_cyc);
    int t;
    clear_mem();
    poke(0, 'h208); poke(1, 'h409); poke(2, 'h00A); poke(3, 'hE00);
    poke(8, 'h005); poke(9, 'hFFB); poke(10, 'h123);
    lat = L; step_en = 0;
    do_reset();
    run_to_halt(t);
    vec++; if (halted !== 1'b1) begin bad++; $display("FAIL prog_halted lat=%0d got %b want 1", L, halted); end
    vec++; if (ram[10] !== 12'h000) begin bad++; $display("FAIL prog_mem10 lat=%0d got %h want 000", L, ram[10]); end
    vec++; if (zflag !== 1'b1) begin bad++; $display("FAIL prog_z lat=%0d got %b want 1", L, zflag); end
    vec++; if (pc !== 9'd3) begin bad++; $display("FAIL prog_pc lat=%0d got %0d want 3", L, pc); end
    vec++; if (t != want_cyc) begin bad++; $display("FAIL prog_cycles lat=%0d got %0d want %0d", L, t, want_cyc); end
    tick(3);
    vec++; if (mem_req !== 1'b0 || halted !== 1'b1 || pc !== 9'd3) begin
      bad++; $display("FAIL halt_stay req=%b halted=%b pc=%0d want 0 1 3", mem_req, halted, pc);
    end
  endtask

  task automatic test_dec_bz();
    int t;
    clear_mem();
    poke(0, 'hA00); poke(1, 'hC00); poke(2, 'h805); poke(3, 'hE00); poke(5, 'hE00);
    lat = 0; step_en = 0;
    do_reset();
    run_to_halt(t);
    vec++; if (acc !== 12'hFFF) begin bad++; $display("FAIL decbz_acc got %h want fff", acc); end
    vec++; if (zflag !== 1'b0) begin bad++; $display("FAIL decbz_z got %b want 0", zflag); end
    vec++; if (pc !== 9'd3) begin bad++; $display("FAIL decbz_pc got %0d want 3", pc); end
    vec++; if (t != 8) begin bad++; $display("FAIL decbz_cycles got %0d want 8", t); end
  endtask

  task automatic test_wait();
    int n;
    clear_mem();
    poke(0, 'hF00); poke(1, 'hE00);
    lat = 0; step_en = 0;
    do_reset();                   // fetch of WAIT is on the bus now, acked this edge
    n = 0;
    while (n < 20) begin
      tick(1);
      if (mem_req) break;
      n++;
    end
    vec++; if (n != WC + 1) begin bad++; $display("FAIL wait_gap got %0d want %0d", n, WC + 1); end
    vec++; if (mem_req !== 1'b1 || mem_addr !== 9'd1 || mem_we !== 1'b0) begin
      bad++; $display("FAIL wait_next_fetch req=%b addr=%0d we=%b want 1 1 0", mem_req, mem_addr, mem_we);
    end
  endtask

  task automatic test_single_step();
    int cyc, nx, base, diffs;
    bit h;
    clear_mem();
    for (int i = 0; i < 64; i++) begin
      int r, cd;
      r = $urandom_range(0, 7);
      if (r <= 2) cd = 256 + $urandom_range(0, 255);
      else if (r <= 4) cd = $urandom_range(0, 63);
      else cd = $urandom_range(0, 511);
      if (r == 7) poke(i, 'hF00);
      else poke(i, r * 512 + cd);
    end
    for (int i = 64; i < 256; i++) poke(i, 'h600);
    for (int i = 256; i < 512; i++) poke(i, int'($urandom_range(0, 4095)));
    lat = $urandom_range(0, 2); spur = 1; step_en = 1;
    model_reset();
    base = n_xact;
    do_reset();                   // first instruction runs straight out of reset
    tick(14);
    model_step(lat, cyc, nx, h);
    vec++; if (pc !== AW'(m_pc) || acc !== DW'(m_acc) || zflag !== m_z || n_xact - base != nx) begin
      bad++; $display("FAIL step0 pc=%0d/%0d acc=%h/%h z=%b/%b xact=%0d/%0d",
                      pc, m_pc, acc, m_acc, zflag, m_z, n_xact - base, nx);
    end
    for (int k = 0; k < 40; k++) begin
      vec++; if (mem_req !== 1'b0) begin bad++; $display("FAIL step_idle_req k=%0d got %b want 0", k, mem_req); end
      base = n_xact;
      step = 1'b1;
      tick(1);
      if (k % 2 == 1) tick(1);    // held step must not start a second instruction
      step = 1'b0;
      tick(13);
      model_step(lat, cyc, nx, h);
      vec++; if (pc !== AW'(m_pc) || acc !== DW'(m_acc) || zflag !== m_z || n_xact - base != nx) begin
        bad++; $display("FAIL step k=%0d pc=%0d/%0d acc=%h/%h z=%b/%b xact=%0d/%0d",
                        k, pc, m_pc, acc, m_acc, zflag, m_z, n_xact - base, nx);
      end
    end
    diffs = 0;
    for (int i = 0; i < 512; i++) if (ram[i] !== ref_mem[i]) diffs++;
    vec++; if (diffs != 0) begin bad++; $display("FAIL step_mem words_differing=%0d want 0", diffs); end
    step_en = 1'b0;
    tick(1);
    vec++; if (mem_req !== 1'b1 || mem_addr !== AW'(m_pc)) begin
      bad++; $display("FAIL step_en_clear req=%b addr=%0d want 1 %0d", mem_req, mem_addr, m_pc);
    end
    spur = 0;
  endtask

  task automatic test_reset_mid_st();
    int n;
    clear_mem();
    poke(0, 'h12C);               // ST 300
    poke(300, 'h5A5);
    lat = 0; step_en = 0; hold_wr = 1;
    do_reset();
    n = 0;
    while (!(mem_req && mem_we) && n < 20) begin tick(1); n++; end
    vec++; if (!(mem_req === 1'b1 && mem_we === 1'b1 && mem_addr === 9'd300)) begin
      bad++; $display("FAIL rst_st_reach req=%b we=%b addr=%0d want 1 1 300", mem_req, mem_we, mem_addr);
    end
    tick(2);
    rst = 1'b1;
    tick(1);
    vec++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_st_abort req=%b want 0", mem_req); end
    vec++; if (ram[300] !== 12'h5A5) begin bad++; $display("FAIL rst_st_mem got %h want 5a5", ram[300]); end
    hold_wr = 0;
    tick(1);
    rst = 1'b0;
    tick(1);
    vec++; if (mem_req !== 1'b1 || mem_addr !== 9'd0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL rst_st_refetch req=%b addr=%0d we=%b want 1 0 0", mem_req, mem_addr, mem_we);
    end
  endtask

  initial begin
    test_reset();
    test_ld_add_st(0, 11);
    test_ld_add_st(3, 32);        // 7 transactions, 3 extra cycles each
    test_dec_bz();
    test_wait();
    test_single_step();
    test_single_step();
    test_reset_mid_st();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
